ahb_slave_arbiter: RTL and testbench

Per-slave arbiter for the AHB_Gen interconnect. It collects the hreq bits that the per-master address decoders raise for one slave and grants a single master at a time. It holds the grant across fixed-length bursts, undefined INCR bursts and locked sequences. It also produces the address-phase and data-phase select indices that drive the slave-side request mux and the response mux.

---
 rtl/ahb_slave_arbiter_pkg.sv | 41 ++++
 rtl/ahb_slave_arbiter_rr_picker.sv | 30 +++
 rtl/ahb_slave_arbiter.sv | 122 ++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types for the per-slave arbiter: transfer/burst encodings and arbiter states.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_INCR  = 2'd2,
        ARB_LOCK  = 2'd3
    } arb_state_type;

    localparam int BEAT_CNT_W = 4;

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats(input hburst_type b);
        case (b)
            WRAP4, INCR4:   return 4'd3;
            WRAP8, INCR8:   return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority or round robin starting after rr_last.
module ahb_rr_picker #(
    parameter int MASTER_NUM      = 4,
    parameter int MASTER_ID_WIDTH = 2
) (
    input  logic [MASTER_NUM-1:0]      req,
    input  logic [MASTER_ID_WIDTH-1:0] rr_last,
    input  logic                       scheme,
    output logic [MASTER_ID_WIDTH-1:0] win_idx,
    output logic                       win_vld
);

    logic [MASTER_ID_WIDTH-1:0] cand;

    // Walk the candidates in priority order and keep the first requester.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            cand = scheme ? MASTER_ID_WIDTH'((int'(rr_last) + 1 + i) % MASTER_NUM)
                          : MASTER_ID_WIDTH'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: grants one master, holds through bursts/INCR/locked
// sequences, and tracks the data-phase owner for the response mux.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM      = 4,
    parameter int ARB_SCHEME      = 1,
    parameter int MASTER_ID_WIDTH = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic       [MASTER_NUM-1:0]       hreq,
    input  htrans_type [MASTER_NUM-1:0]       htrans_m,
    input  hburst_type [MASTER_NUM-1:0]       hburst_m,
    input  logic       [MASTER_NUM-1:0]       hmastlock_m,
    input  logic                              hready,
    output logic       [MASTER_NUM-1:0]       hgrant,
    output logic       [MASTER_ID_WIDTH-1:0]  addr_sel,
    output logic       [MASTER_ID_WIDTH-1:0]  data_sel,
    output logic                              data_active,
    output logic                              hmastlock
);

    arb_state_type              state_q, state_d;
    logic                       grant_vld_q, grant_vld_d;
    logic [MASTER_ID_WIDTH-1:0] addr_sel_q, addr_sel_d;
    logic [MASTER_ID_WIDTH-1:0] data_sel_q, data_sel_d;
    logic [MASTER_ID_WIDTH-1:0] rr_last_q, rr_last_d;
    logic [BEAT_CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                       data_active_q, data_active_d;

    htrans_type                 own_trans;
    hburst_type                 own_burst;
    logic                       own_lock;
    logic                       own_req;
    logic                       release_c;
    logic [MASTER_ID_WIDTH-1:0] win_idx;
    logic                       win_vld;

    ahb_rr_picker #(
        .MASTER_NUM      (MASTER_NUM),
        .MASTER_ID_WIDTH (MASTER_ID_WIDTH)
    ) u_picker (
        .req     (hreq),
        .rr_last (rr_last_q),
        .scheme  (ARB_SCHEME != 0),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Owner's view of the bus and whether its current transfer ends the tenure.
    always_comb begin
        own_trans = htrans_m[addr_sel_q];
        own_burst = hburst_m[addr_sel_q];
        own_lock  = hmastlock_m[addr_sel_q];
        own_req   = hreq[addr_sel_q];
        release_c = grant_vld_q && !own_lock &&
                    (!own_req ||
                     (own_trans == IDLE) ||
                     (own_trans == NONSEQ && own_burst == SINGLE) ||
                     (own_trans == SEQ && state_q == ARB_BURST && beat_cnt_q == 4'd1));
    end

    // Next-state: beat counting, hold/release, re-arbitration and data-phase tracking.
    always_comb begin
        state_d       = state_q;
        grant_vld_d   = grant_vld_q;
        addr_sel_d    = addr_sel_q;
        rr_last_d     = rr_last_q;
        beat_cnt_d    = beat_cnt_q;
        data_sel_d    = addr_sel_q;
        data_active_d = grant_vld_q && (own_trans == NONSEQ || own_trans == SEQ);

        if (grant_vld_q && own_trans == NONSEQ)
            beat_cnt_d = burst_beats(own_burst);
        else if (grant_vld_q && own_trans == SEQ && beat_cnt_q != '0)
            beat_cnt_d = beat_cnt_q - 4'd1;

        if (!grant_vld_q || release_c) begin
            // New owner is only classified once its own NONSEQ is accepted.
            state_d     = ARB_IDLE;
            grant_vld_d = win_vld;
            if (win_vld) begin
                addr_sel_d = win_idx;
                if (ARB_SCHEME != 0)
                    rr_last_d = win_idx;
            end
        end else if (own_lock) begin
            state_d = ARB_LOCK;
        end else if (own_trans == NONSEQ) begin
            state_d = (own_burst == INCR) ? ARB_INCR : ARB_BURST;
        end
    end

    // State registers; everything stalls while the slave holds hready low.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q       <= ARB_IDLE;
            grant_vld_q   <= 1'b0;
            addr_sel_q    <= '0;
            data_sel_q    <= '0;
            rr_last_q     <= MASTER_ID_WIDTH'(MASTER_NUM - 1);
            beat_cnt_q    <= '0;
            data_active_q <= 1'b0;
        end else if (hready) begin
            state_q       <= state_d;
            grant_vld_q   <= grant_vld_d;
            addr_sel_q    <= addr_sel_d;
            data_sel_q    <= data_sel_d;
            rr_last_q     <= rr_last_d;
            beat_cnt_q    <= beat_cnt_d;
            data_active_q <= data_active_d;
        end
    end

    assign hgrant      = grant_vld_q ? (MASTER_NUM'(1) << addr_sel_q) : '0;
    assign addr_sel    = addr_sel_q;
    assign data_sel    = data_sel_q;
    assign data_active = data_active_q;
    assign hmastlock   = grant_vld_q && own_lock;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench: vector table, directed burst/lock/reset sequences, and random traffic
// against a behavioural model for both round-robin and fixed-priority builds.
module tb_ahb_slave_arbiter;
    import ahb_slave_arbiter_pkg::*;

    localparam int NM = 4;
    localparam int IW = 2;

    logic                hclk = 1'b0;
    logic                hreset;
    logic       [NM-1:0] hreq;
    htrans_type [NM-1:0] htrans_m;
    hburst_type [NM-1:0] hburst_m;
    logic       [NM-1:0] hmastlock_m;
    logic                hready;

    logic [NM-1:0] g_rr, g_fp;
    logic [IW-1:0] as_rr, as_fp, ds_rr, ds_fp;
    logic          da_rr, da_fp, ml_rr, ml_fp;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(.MASTER_NUM(NM), .ARB_SCHEME(1)) dut (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans_m(htrans_m),
        .hburst_m(hburst_m), .hmastlock_m(hmastlock_m), .hready(hready),
        .hgrant(g_rr), .addr_sel(as_rr), .data_sel(ds_rr),
        .data_active(da_rr), .hmastlock(ml_rr));

    ahb_slave_arbiter #(.MASTER_NUM(NM), .ARB_SCHEME(0)) dut_fp (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans_m(htrans_m),
        .hburst_m(hburst_m), .hmastlock_m(hmastlock_m), .hready(hready),
        .hgrant(g_fp), .addr_sel(as_fp), .data_sel(ds_fp),
        .data_active(da_fp), .hmastlock(ml_fp));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_all(input logic [3:0] req, input htrans_type tr,
                             input hburst_type bu, input logic [3:0] lk);
        hreq        = req;
        hmastlock_m = lk;
        for (int i = 0; i < NM; i++) begin
            htrans_m[i] = tr;
            hburst_m[i] = bu;
        end
    endtask

    // ---------------- behavioural model (index 0: round robin, 1: fixed) ----
    int m_gnt[2], m_asel[2], m_dsel[2], m_dact[2], m_cnt[2], m_mode[2], m_rr[2];

    task automatic model_reset(input int k);
        m_gnt[k] = 0; m_asel[k] = 0; m_dsel[k] = 0; m_dact[k] = 0;
        m_cnt[k] = 0; m_mode[k] = 0; m_rr[k] = NM - 1;
    endtask

    // Modes: 0 none, 1 fixed burst, 2 open INCR, 3 locked.
    task automatic model_step(input int k, input int rr);
        int o, tr, bu, lk, w, c;
        bit rel;
        if (hreset) begin model_reset(k); return; end
        if (!hready) return;
        o   = m_asel[k];
        tr  = int'(htrans_m[o]);
        bu  = int'(hburst_m[o]);
        lk  = int'(hmastlock_m[o]);
        rel = (m_gnt[k] != 0) && (lk == 0) &&
              (!hreq[o] || tr == 0 || (tr == 2 && bu == 0) ||
               (tr == 3 && m_mode[k] == 1 && m_cnt[k] == 1));
        m_dsel[k] = o;
        m_dact[k] = (m_gnt[k] != 0 && tr >= 2) ? 1 : 0;
        if (m_gnt[k] != 0 && tr == 2)
            m_cnt[k] = (bu >= 2) ? (1 << (bu / 2 + 1)) - 1 : 0;
        else if (m_gnt[k] != 0 && tr == 3 && m_cnt[k] > 0)
            m_cnt[k] = m_cnt[k] - 1;
        if (m_gnt[k] == 0 || rel) begin
            m_mode[k] = 0;
            w = -1;
            for (int i = 0; i < NM; i++) begin
                c = (rr != 0) ? (m_rr[k] + 1 + i) % NM : i;
                if (w < 0 && hreq[c]) w = c;
            end
            if (w >= 0) begin
                m_gnt[k] = 1; m_asel[k] = w;
                if (rr != 0) m_rr[k] = w;
            end else begin
                m_gnt[k] = 0;
            end
        end else if (lk != 0) begin
            m_mode[k] = 3;
        end else if (tr == 2) begin
            m_mode[k] = (bu == 1) ? 2 : 1;
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int k);
        return (m_gnt[k] != 0) ? 4'(1 << m_asel[k]) : 4'b0000;
    endfunction

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic       rst;
        logic       rdy;
        logic [3:0] req;
        htrans_type tr;
        hburst_type bu;
        logic [3:0] g_rr;
        logic [3:0] g_fp;
        logic       dact;
    } vec_t;

    vec_t vt[12];

    initial begin
        hreset = 1'b1; hready = 1'b1;
        drive_all(4'b0000, IDLE, SINGLE, 4'b0000);

        vt[0]  = '{1'b1, 1'b1, 4'b0000, IDLE,   SINGLE, 4'b0000, 4'b0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 4'b0001, NONSEQ, SINGLE, 4'b0001, 4'b0001, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 4'b0001, NONSEQ, SINGLE, 4'b0001, 4'b0001, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 4'b0000, IDLE,   SINGLE, 4'b0000, 4'b0000, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 4'b0000, IDLE,   SINGLE, 4'b0000, 4'b0000, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b0001, 4'b0001, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b0010, 4'b0001, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b0100, 4'b0001, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b1000, 4'b0001, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b0001, 4'b0001, 1'b1};
        vt[10] = '{1'b0, 1'b0, 4'b1111, NONSEQ, SINGLE, 4'b0001, 4'b0001, 1'b1};
        vt[11] = '{1'b1, 1'b1, 4'b1111, NONSEQ, SINGLE, 4'b0000, 4'b0000, 1'b0};

        for (int r = 0; r < 12; r++) begin
            hreset = vt[r].rst;
            hready = vt[r].rdy;
            drive_all(vt[r].req, vt[r].tr, vt[r].bu, 4'b0000);
            tick();
            chk($sformatf("vec%0d hgrant_rr", r), 32'(g_rr), 32'(vt[r].g_rr));
            chk($sformatf("vec%0d hgrant_fp", r), 32'(g_fp), 32'(vt[r].g_fp));
            chk($sformatf("vec%0d data_active", r), 32'(da_rr), 32'(vt[r].dact));
        end

        // ---- INCR4 with two BUSY beats and a 3-cycle stall, master 2 waiting
        hreset = 1'b1; hready = 1'b1;
        drive_all(4'b0000, IDLE, SINGLE, 4'b0000);
        tick();
        hreset = 1'b0;
        hreq = 4'b0010; htrans_m[1] = NONSEQ; hburst_m[1] = INCR4;
        tick();
        chk("incr4 grant", 32'(g_rr), 32'h2);
        hreq = 4'b0110; htrans_m[2] = NONSEQ; hburst_m[2] = SINGLE;
        tick();
        chk("incr4 beat1", 32'(g_rr), 32'h2);
        htrans_m[1] = BUSY;
        tick();
        chk("incr4 busy1", 32'(g_rr), 32'h2);
        htrans_m[1] = SEQ;
        tick();
        chk("incr4 beat2", 32'(g_rr), 32'h2);
        hready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stall%0d hgrant", s), 32'(g_rr), 32'h2);
            chk($sformatf("stall%0d addr_sel", s), 32'(as_rr), 32'd1);
            chk($sformatf("stall%0d beat_cnt", s), 32'(dut.beat_cnt_q), 32'd2);
            chk($sformatf("stall%0d data_active", s), 32'(da_rr), 32'd1);
        end
        hready = 1'b1;
        htrans_m[1] = BUSY;
        tick();
        chk("incr4 busy2", 32'(g_rr), 32'h2);
        htrans_m[1] = SEQ;
        tick();
        chk("incr4 beat3", 32'(g_rr), 32'h2);
        tick();
        chk("incr4 handover", 32'(g_rr), 32'h4);
        chk("incr4 addr_sel", 32'(as_rr), 32'd2);
        chk("incr4 data_sel", 32'(ds_rr), 32'd1);
        chk("incr4 last dact", 32'(da_rr), 32'd1);

        // ---- locked master 3 across two INCR bursts with IDLE between
        hreset = 1'b1;
        drive_all(4'b0000, IDLE, SINGLE, 4'b0000);
        tick();
        hreset = 1'b0;
        hreq = 4'b1000; hmastlock_m = 4'b1000;
        htrans_m[3] = NONSEQ; hburst_m[3] = INCR;
        tick();
        chk("lock grant", 32'(g_rr), 32'h8);
        chk("lock hmastlock", 32'(ml_rr), 32'd1);
        hreq = 4'b1001; htrans_m[0] = NONSEQ;
        tick();
        htrans_m[3] = SEQ;
        tick();
        htrans_m[3] = IDLE;
        tick();
        chk("lock hold over idle", 32'(g_rr), 32'h8);
        chk("lock hmastlock idle", 32'(ml_rr), 32'd1);
        htrans_m[3] = NONSEQ;
        tick();
        htrans_m[3] = SEQ;
        tick();
        chk("lock second burst", 32'(g_rr), 32'h8);
        hmastlock_m = 4'b0000; htrans_m[3] = IDLE;
        #1;
        chk("lock dropped comb", 32'(ml_rr), 32'd0);
        tick();
        chk("lock release", 32'(g_rr), 32'h1);

        // ---- reset at beat 5 of an INCR8
        hreset = 1'b1;
        drive_all(4'b0000, IDLE, SINGLE, 4'b0000);
        tick();
        hreset = 1'b0;
        hreq = 4'b0100; htrans_m[2] = NONSEQ; hburst_m[2] = INCR8;
        tick();
        chk("incr8 grant", 32'(g_rr), 32'h4);
        tick();
        htrans_m[2] = SEQ;
        for (int b = 0; b < 4; b++) tick();
        chk("incr8 beat_cnt", 32'(dut.beat_cnt_q), 32'd3);
        chk("incr8 still owned", 32'(g_rr), 32'h4);
        hreset = 1'b1;
        tick();
        chk("rst hgrant", 32'(g_rr), 32'h0);
        chk("rst data_active", 32'(da_rr), 32'd0);
        chk("rst state", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("rst rr_last", 32'(dut.rr_last_q), 32'd3);
        hreset = 1'b0;

        // ---- random traffic vs model
        hreset = 1'b1;
        drive_all(4'b0000, IDLE, SINGLE, 4'b0000);
        tick();
        model_reset(0);
        model_reset(1);
        hreset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            hreset = ($urandom_range(0, 63) == 0);
            hready = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < NM; i++) begin
                hreq[i]        = ($urandom_range(0, 99) < 85);
                htrans_m[i]    = htrans_type'($urandom_range(0, 3));
                hburst_m[i]    = hburst_type'($urandom_range(0, 7));
                hmastlock_m[i] = ($urandom_range(0, 99) < 15);
            end
            @(negedge hclk);
            chk($sformatf("rnd%0d rr hgrant", c), 32'(g_rr), 32'(exp_gnt(0)));
            chk($sformatf("rnd%0d rr addr_sel", c), 32'(as_rr), 32'(m_asel[0]));
            chk($sformatf("rnd%0d rr data_sel", c), 32'(ds_rr), 32'(m_dsel[0]));
            chk($sformatf("rnd%0d rr data_active", c), 32'(da_rr), 32'(m_dact[0]));
            chk($sformatf("rnd%0d rr hmastlock", c), 32'(ml_rr),
                32'((m_gnt[0] != 0) && hmastlock_m[m_asel[0]]));
            chk($sformatf("rnd%0d fp hgrant", c), 32'(g_fp), 32'(exp_gnt(1)));
            chk($sformatf("rnd%0d fp data_sel", c), 32'(ds_fp), 32'(m_dsel[1]));
            chk($sformatf("rnd%0d fp data_active", c), 32'(da_fp), 32'(m_dact[1]));
            chk($sformatf("rnd%0d fp hmastlock", c), 32'(ml_fp),
                32'((m_gnt[1] != 0) && hmastlock_m[m_asel[1]]));
            @(posedge hclk);
            model_step(0, 1);
            model_step(1, 0);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
